// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared configuration for the instruction fetch stage: boot address, NOP
//   encoding, FSM state encodings and the state enum used by fetch_unit.
//
//   Configuration macros defined here:
//      TEXT_BEGIN          PC loaded on reset (start of .text)
//      INST_NOP            canonical RV32 NOP (addi x0, x0, 0)
//      FETCH_STATE_FETCH   encoding of the FETCH state
//      FETCH_STATE_DRAIN   encoding of the DRAIN state
//      FETCH_STATE_HALT    encoding of the HALT state
//
//   Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds the HALT state).
// -----------------------------------------------------------------------------
`define TEXT_BEGIN        32'h0040_0000
`define INST_NOP          32'h0000_0013
`define FETCH_STATE_FETCH 2'd0
`define FETCH_STATE_DRAIN 2'd1
`define FETCH_STATE_HALT  2'd2

package fetch_unit_pkg;

   localparam logic [31:0] BOOT_ADDRESS = `TEXT_BEGIN;
   localparam logic [31:0] INST_NOP     = `INST_NOP;

   // Width of one buffered decode entry: {pc, inst}.
   localparam int unsigned ENTRY_W = 64;

   typedef enum logic [1:0] {
      ST_FETCH = `FETCH_STATE_FETCH,
      ST_DRAIN = `FETCH_STATE_DRAIN
`ifdef FETCH_MISALIGN_TRAP_EN
      , ST_HALT = `FETCH_STATE_HALT
`endif
   } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   2-entry synchronous FIFO. Used for the {pc, inst} data buffer (64 bits)
//   and for the request tag queue (32 bits).
//
//   Ports:
//      clock      in   rising-edge clock
//      reset      in   synchronous active-high reset, empties the FIFO
//      push       in   write wdata (ignored when full unless popping too)
//      pop        in   discard the head entry (ignored when empty)
//      flush      in   empty the FIFO; has priority over push and pop
//      wdata      in   WIDTH-bit entry to write
//      head       out  oldest entry; stale when occupancy == 0
//      occupancy  out  number of valid entries, 0..2
// -----------------------------------------------------------------------------
module fetch_buffer #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       occupancy
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != 2'd0);
   // A full FIFO can still take a write when the head leaves the same cycle.
   assign do_push = push && ((count != 2'd2) || do_pop);

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head      = mem[rd_ptr];
   assign occupancy = count;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   RV32 instruction fetch stage. Owns the PC, issues word requests to
//   instruction memory, buffers returned words and hands {pc, inst} to decode.
//   Redirects from execute flush every fetched word and restart at a new PC.
//
//   Ports:
//      clock            in   sole clock, rising edge
//      reset            in   synchronous, active-high
//      imem_req         out  fetch request
//      imem_addr        out  word address of the request (4-byte aligned)
//      imem_gnt         in   request accepted this cycle
//      imem_rvalid      in   in-order response valid (>= 1 cycle after grant)
//      imem_rdata       in   instruction word of the response
//      redirect_valid   in   flush and restart fetch
//      redirect_target  in   new PC
//      id_valid         out  instruction available to decode
//      id_ready         in   decode accepts
//      id_inst          out  instruction word (holds last value when empty)
//      id_pc            out  address of id_inst (holds last value when empty)
//      misaligned_exc   out  in HALT after a misaligned redirect
//                            (only with FETCH_MISALIGN_TRAP_EN)
//      fetch_state      out  current FSM state (debug)
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high (imem_req/imem_gnt, id_valid/id_ready). The producer holds valid
//   and payload until the transfer, except that a redirect withdraws both.
//
//   Macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets enter HALT and
//   raise misaligned_exc. Without it the low target bits are forced to zero.
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic        misaligned_exc,
`endif
   output logic [1:0]  fetch_state
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [1:0]   discard;
   logic [1:0]   outstanding;
   logic [1:0]   occupancy;
   logic [1:0]   out_after_rsp;
   logic [2:0]   credit;
   logic         fire;
   logic         push_buf;
   logic         pop_buf;
   logic [31:0]  tag_head;
   logic [63:0]  buf_head;
   logic [31:0]  last_inst;
   logic [31:0]  last_pc;
   logic [1:0]   target_low;
   logic [31:0]  pc_target;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic         target_misaligned;
   logic         halt_pending;
`endif

   // ---------------------------------------------------------------- targets
`ifdef FETCH_MISALIGN_TRAP_EN
   assign target_misaligned = (redirect_target[1:0] != 2'b00);
`endif
   // The PC register only ever holds word addresses.
   assign target_low = redirect_target[1:0] & 2'b00;
   assign pc_target  = {redirect_target[31:2], target_low};

   // ------------------------------------------------------------ issue logic
   // Every outstanding request has a reserved buffer slot, so the buffer can
   // never overflow: outstanding + occupancy never exceeds 2.
   assign credit    = {1'b0, outstanding} + {1'b0, occupancy};
   assign imem_req  = !reset && (state == ST_FETCH) && !redirect_valid &&
                      (credit < 3'd2);
   assign imem_addr = pc;
   assign fire      = imem_req && imem_gnt;

   // Outstanding requests after this cycle's response, before any new grant.
   assign out_after_rsp = outstanding - {1'b0, imem_rvalid};

   // A response is kept only when no redirect is in flight and no stale
   // responses remain to be dropped.
   assign push_buf = imem_rvalid && !redirect_valid && (discard == 2'd0);
   assign pop_buf  = id_valid && id_ready;

   // ------------------------------------------------------------- tag queue
   // Holds the PC of every granted request until its response returns, so
   // its occupancy is exactly the outstanding-request count. Responses that
   // are discarded still retire their tag, which keeps the queue aligned.
   fetch_buffer #(.WIDTH(32)) u_tag_queue (
      .clock     (clock),
      .reset     (reset),
      .push      (fire),
      .pop       (imem_rvalid),
      .flush     (1'b0),
      .wdata     (pc),
      .head      (tag_head),
      .occupancy (outstanding)
   );

   // ----------------------------------------------------------- data buffer
   fetch_buffer #(.WIDTH(ENTRY_W)) u_data_buffer (
      .clock     (clock),
      .reset     (reset),
      .push      (push_buf),
      .pop       (pop_buf),
      .flush     (redirect_valid),
      .wdata     ({tag_head, imem_rdata}),
      .head      (buf_head),
      .occupancy (occupancy)
   );

   // ------------------------------------------------------ decode interface
   assign id_valid = (occupancy != 2'd0);
   assign id_inst  = id_valid ? buf_head[31:0]  : last_inst;
   assign id_pc    = id_valid ? buf_head[63:32] : last_pc;

   // Remember the most recently presented entry so the outputs hold steady
   // while the buffer is empty.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_inst <= INST_NOP;
         last_pc   <= BOOT_ADDRESS;
      end else if (id_valid) begin
         last_inst <= buf_head[31:0];
         last_pc   <= buf_head[63:32];
      end
   end

   // ------------------------------------------------- FSM, PC and discards
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_FETCH;
         pc      <= BOOT_ADDRESS;
         discard <= 2'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
         halt_pending <= 1'b0;
`endif
      end else if (redirect_valid) begin
         // No request is issued this cycle, so every request still pending
         // after this cycle's response belongs to the old path.
         pc      <= pc_target;
         discard <= out_after_rsp;
`ifdef FETCH_MISALIGN_TRAP_EN
         halt_pending <= target_misaligned;
`endif
         if (out_after_rsp != 2'd0) begin
            state <= ST_DRAIN;
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         else if (target_misaligned) begin
            state <= ST_HALT;
         end
`endif
         else begin
            state <= ST_FETCH;
         end
      end else begin
         if (fire) begin
            pc <= pc + 32'd4;
         end
         if (imem_rvalid && (discard != 2'd0)) begin
            discard <= discard - 2'd1;
         end
         case (state)
            ST_DRAIN: begin
               if (discard == 2'd0) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                  state <= halt_pending ? ST_HALT : ST_FETCH;
`else
                  state <= ST_FETCH;
`endif
               end
            end
            default: state <= state;
         endcase
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   assign misaligned_exc = (state == ST_HALT);
`endif
   assign fetch_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A cycle table covers boot, steady
//   fetch, backpressure and a redirect with two responses pending; short
//   hand-written sequences cover simultaneous redirect/response/handshake,
//   mid-run reset, PC wrap and misaligned redirects. The instruction memory
//   model answers each grant one cycle later with ~address as the data word.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] BOOT = 32'h0040_0000;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clock;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [1:0]  fetch_state;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misaligned_exc;
`endif

   fetch_unit dut (
      .clock           (clock),
      .reset           (reset),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_inst         (id_inst),
      .id_pc           (id_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
      .misaligned_exc  (misaligned_exc),
`endif
      .fetch_state     (fetch_state)
   );

   // ------------------------------------------------------ clock generation
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // -------------------------------------------------------- scoreboard
   int n_vec = 0;
   int n_err = 0;
   logic [31:0] resp_q[$];   // addresses granted, awaiting a response

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // --------------------------------------------------------- driver tasks
   // Called at posedge+1: set inputs for this cycle and drive the memory
   // response (one cycle after its grant unless stalled), then settle.
   task automatic begin_cycle(input logic ready, input logic stall,
                              input logic redir, input logic [31:0] tgt);
      logic [31:0] a;
      reset           = 1'b0;
      id_ready        = ready;
      redirect_valid  = redir;
      redirect_target = tgt;
      imem_gnt        = 1'b1;
      if (!stall && resp_q.size() > 0) begin
         a           = resp_q.pop_front();
         imem_rvalid = 1'b1;
         imem_rdata  = ~a;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'h0;
      end
      #1;
   endtask

   // Record this cycle's grant at the falling edge, then advance to posedge+1.
   task automatic end_cycle();
      @(negedge clock);
      if (!reset && imem_req && imem_gnt) resp_q.push_back(imem_addr);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input string tag);
      for (int i = 0; i < 2; i++) begin
         reset          = 1'b1;
         redirect_valid = 1'b0;
         id_ready       = 1'b1;
         imem_rvalid    = 1'b0;
         imem_rdata     = 32'h0;
         resp_q.delete();
         #1;
         check($sformatf("%s req in reset %0d", tag, i), {31'b0, imem_req}, 32'd0);
         if (i == 1) begin
            check({tag, " valid"}, {31'b0, id_valid}, 32'd0);
            check({tag, " inst"},  id_inst, NOP);
            check({tag, " pc"},    id_pc, BOOT);
            check({tag, " state"}, {30'b0, fetch_state}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
            check({tag, " exc"},   {31'b0, misaligned_exc}, 32'd0);
`endif
         end
         end_cycle();
      end
   endtask

   // ----------------------------------------------------------- vector table
   typedef struct {
      logic        ready;
      logic        stall;
      logic        redir;
      logic [31:0] tgt;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
      logic [1:0]  exp_state;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs[NV];

   task automatic set_vec(input int i, input logic rd, input logic st,
                          input logic rdr, input logic [31:0] tg,
                          input logic rq, input logic [31:0] ad,
                          input logic vl, input logic [31:0] p,
                          input logic [31:0] ins, input logic [1:0] s);
      vecs[i].ready     = rd;
      vecs[i].stall     = st;
      vecs[i].redir     = rdr;
      vecs[i].tgt       = tg;
      vecs[i].exp_req   = rq;
      vecs[i].exp_addr  = ad;
      vecs[i].exp_valid = vl;
      vecs[i].exp_pc    = p;
      vecs[i].exp_inst  = ins;
      vecs[i].exp_state = s;
   endtask

   initial begin
      reset           = 1'b1;
      id_ready        = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      imem_gnt        = 1'b1;
      imem_rvalid     = 1'b0;
      imem_rdata      = 32'h0;

      //          i  rdy stl rdr tgt           req addr          vld pc            inst                st
      // boot, 1-cycle memory, decode always ready
      set_vec( 0, 1, 0, 0, 32'h0,          1, 32'h0040_0000, 0, 32'h0040_0000, NOP,                0);
      set_vec( 1, 1, 0, 0, 32'h0,          1, 32'h0040_0004, 0, 32'h0040_0000, NOP,                0);
      set_vec( 2, 1, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0040_0000, ~32'h0040_0000,     0);
      set_vec( 3, 1, 0, 0, 32'h0,          1, 32'h0040_0008, 1, 32'h0040_0004, ~32'h0040_0004,     0);
      set_vec( 4, 1, 0, 0, 32'h0,          1, 32'h0040_000C, 0, 32'h0040_0004, ~32'h0040_0004,     0);
      set_vec( 5, 1, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0040_0008, ~32'h0040_0008,     0);
      // backpressure: buffer fills to two entries, requests stop
      set_vec( 6, 0, 0, 0, 32'h0,          1, 32'h0040_0010, 1, 32'h0040_000C, ~32'h0040_000C,     0);
      set_vec( 7, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0040_000C, ~32'h0040_000C,     0);
      set_vec( 8, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0040_000C, ~32'h0040_000C,     0);
      set_vec( 9, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0040_000C, ~32'h0040_000C,     0);
      set_vec(10, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0040_000C, ~32'h0040_000C,     0);
      set_vec(11, 1, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0040_000C, ~32'h0040_000C,     0);
      set_vec(12, 1, 0, 0, 32'h0,          1, 32'h0040_0014, 1, 32'h0040_0010, ~32'h0040_0010,     0);
      set_vec(13, 1, 0, 0, 32'h0,          1, 32'h0040_0018, 0, 32'h0040_0010, ~32'h0040_0010,     0);
      // responses stalled to build two outstanding requests, then redirect
      set_vec(14, 1, 1, 0, 32'h0,          0, 32'h0,         1, 32'h0040_0014, ~32'h0040_0014,     0);
      set_vec(15, 1, 1, 0, 32'h0,          1, 32'h0040_001C, 0, 32'h0040_0014, ~32'h0040_0014,     0);
      set_vec(16, 1, 1, 1, 32'h0040_0100,  0, 32'h0,         0, 32'h0040_0014, ~32'h0040_0014,     0);
      set_vec(17, 1, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0040_0014, ~32'h0040_0014,     1);
      set_vec(18, 1, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0040_0014, ~32'h0040_0014,     1);
      set_vec(19, 1, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0040_0014, ~32'h0040_0014,     1);
      set_vec(20, 1, 0, 0, 32'h0,          1, 32'h0040_0100, 0, 32'h0040_0014, ~32'h0040_0014,     0);
      set_vec(21, 1, 0, 0, 32'h0,          1, 32'h0040_0104, 0, 32'h0040_0014, ~32'h0040_0014,     0);
      set_vec(22, 1, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0040_0100, ~32'h0040_0100,     0);

      @(posedge clock);
      #1;
      do_reset("boot");

      for (int i = 0; i < NV; i++) begin
         begin_cycle(vecs[i].ready, vecs[i].stall, vecs[i].redir, vecs[i].tgt);
         check($sformatf("v%0d req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
         if (vecs[i].exp_req)
            check($sformatf("v%0d addr", i), imem_addr, vecs[i].exp_addr);
         check($sformatf("v%0d valid", i), {31'b0, id_valid}, {31'b0, vecs[i].exp_valid});
         check($sformatf("v%0d pc", i), id_pc, vecs[i].exp_pc);
         check($sformatf("v%0d inst", i), id_inst, vecs[i].exp_inst);
         check($sformatf("v%0d state", i), {30'b0, fetch_state}, {30'b0, vecs[i].exp_state});
         end_cycle();
      end

      // ---- redirect, response and decode handshake in the same cycle
      begin_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      check("sim a0 req",  {31'b0, imem_req}, 32'd1);
      check("sim a0 addr", imem_addr, 32'h0040_0108);
      check("sim a0 pc",   id_pc, 32'h0040_0104);
      end_cycle();
      begin_cycle(1'b1, 1'b0, 1'b1, 32'h0040_0300);
      check("sim a1 rvalid seen", {31'b0, imem_rvalid}, 32'd1);
      check("sim a1 req",   {31'b0, imem_req}, 32'd0);
      check("sim a1 valid", {31'b0, id_valid}, 32'd1);
      check("sim a1 pc",    id_pc, 32'h0040_0104);
      end_cycle();
      begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("sim a2 valid", {31'b0, id_valid}, 32'd0);
      check("sim a2 req",   {31'b0, imem_req}, 32'd1);
      check("sim a2 addr",  imem_addr, 32'h0040_0300);
      check("sim a2 hold pc", id_pc, 32'h0040_0104);
      end_cycle();
      begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("sim a3 addr",  imem_addr, 32'h0040_0304);
      check("sim a3 valid", {31'b0, id_valid}, 32'd0);
      end_cycle();
      begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("sim a4 valid", {31'b0, id_valid}, 32'd1);
      check("sim a4 pc",    id_pc, 32'h0040_0300);
      check("sim a4 inst",  id_inst, ~32'h0040_0300);
      end_cycle();

      // ---- reset mid-operation, then PC wrap
      do_reset("mid");
      begin_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      check("wrap b0 req", {31'b0, imem_req}, 32'd0);
      end_cycle();
      begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("wrap b1 addr", imem_addr, 32'hFFFF_FFFC);
      check("wrap b1 req",  {31'b0, imem_req}, 32'd1);
      end_cycle();
      begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("wrap b2 addr", imem_addr, 32'h0000_0000);
      end_cycle();
      begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("wrap b3 pc",   id_pc, 32'hFFFF_FFFC);
      check("wrap b3 inst", id_inst, 32'h0000_0003);
      end_cycle();
      begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("wrap b4 pc",   id_pc, 32'h0000_0000);
      check("wrap b4 inst", id_inst, 32'hFFFF_FFFF);
      end_cycle();

      // ---- misaligned redirect
      do_reset("mis");
      begin_cycle(1'b1, 1'b0, 1'b1, 32'h0040_0102);
      check("mis c0 req", {31'b0, imem_req}, 32'd0);
      end_cycle();
`ifdef FETCH_MISALIGN_TRAP_EN
      for (int i = 1; i <= 2; i++) begin
         begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
         check($sformatf("mis c%0d exc", i),   {31'b0, misaligned_exc}, 32'd1);
         check($sformatf("mis c%0d req", i),   {31'b0, imem_req}, 32'd0);
         check($sformatf("mis c%0d valid", i), {31'b0, id_valid}, 32'd0);
         check($sformatf("mis c%0d state", i), {30'b0, fetch_state}, 32'd2);
         end_cycle();
      end
      begin_cycle(1'b1, 1'b0, 1'b1, 32'h0040_0200);
      check("mis c3 exc", {31'b0, misaligned_exc}, 32'd1);
      check("mis c3 req", {31'b0, imem_req}, 32'd0);
      end_cycle();
      begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("mis c4 exc",   {31'b0, misaligned_exc}, 32'd0);
      check("mis c4 req",   {31'b0, imem_req}, 32'd1);
      check("mis c4 addr",  imem_addr, 32'h0040_0200);
      check("mis c4 state", {30'b0, fetch_state}, 32'd0);
      end_cycle();
`else
      begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("mis c1 req",   {31'b0, imem_req}, 32'd1);
      check("mis c1 addr",  imem_addr, 32'h0040_0100);
      check("mis c1 state", {30'b0, fetch_state}, 32'd0);
      end_cycle();
      begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("mis c2 addr", imem_addr, 32'h0040_0104);
      end_cycle();
      begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("mis c3 pc",   id_pc, 32'h0040_0100);
      check("mis c3 inst", id_inst, ~32'h0040_0100);
      end_cycle();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
